// File: rtl/ff_write_arbiter.sv
// ff_write_arbiter: four requesters share one WIDTH-bit register.
// A two-state FSM (IDLE/GRANT) hands out a registered one-hot grant in
// round-robin order. A locked requester may keep the grant for up to
// MAX_BURST consecutive cycles. A write commits on any cycle where the
// granted requester still asserts req.
module ff_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [3:0]         lock,
    input  logic [4*WIDTH-1:0] data,
    output logic [3:0]         gnt,
    output logic [3:0]         ack,
    output logic [WIDTH-1:0]   q,
    output logic               busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [3:0]         burst_cnt_q, burst_cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;

    logic [WIDTH-1:0]   data_arr [4];
    logic [1:0]         gnt_idx;
    logic [1:0]         rr_base;
    logic [1:0]         win_idx;
    logic [1:0]         scan_idx;
    logic               keep_grant;
    logic               wr_en;

    // Split the flat data bus into one slice per requester.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            assign data_arr[gi] = data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Encode the current one-hot grant into the index of the holder.
    always_comb begin
        gnt_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (gnt_q[i]) gnt_idx = 2'(i);
        end
    end

    // Pick the first requesting index at or after rr_base, wrapping mod 4.
    // In GRANT the search starts just past the current holder, which is
    // the pointer value the FSM stores when the grant moves on.
    always_comb begin
        rr_base  = (state_q == GRANT) ? gnt_idx + 2'd1 : rr_ptr_q;
        win_idx  = rr_base;
        scan_idx = rr_base;
        // Scan from the farthest offset down so the nearest request wins.
        for (int i = 3; i >= 0; i--) begin
            scan_idx = rr_base + 2'(i);
            if (req[scan_idx]) win_idx = scan_idx;
        end
    end

    // Holder keeps the grant only while it requests, locks and has burst left.
    assign keep_grant = req[gnt_idx] && lock[gnt_idx] &&
                        (burst_cnt_q < 4'(MAX_BURST));

    // A write commits whenever the granted requester is still requesting.
    assign wr_en = |(gnt_q & req);

    // Next-state, next-grant, pointer, burst counter and register contents.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        q_d         = wr_en ? data_arr[gnt_idx] : q_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANT;
                    gnt_d       = 4'b0001 << win_idx;
                    burst_cnt_d = 4'd1;
                end else begin
                    gnt_d       = 4'b0000;
                    burst_cnt_d = 4'd0;
                end
            end
            GRANT: begin
                if (keep_grant) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end else begin
                    rr_ptr_d = gnt_idx + 2'd1;
                    if (|req) begin
                        gnt_d       = 4'b0001 << win_idx;
                        burst_cnt_d = 4'd1;
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = 4'b0000;
                        burst_cnt_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 4'b0000;
                burst_cnt_d = 4'd0;
            end
        endcase
    end

    // State registers; reset clears everything, including a pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 4'b0000;
            rr_ptr_q    <= 2'd0;
            burst_cnt_q <= 4'd0;
            q_q         <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            q_q         <= q_d;
        end
    end

    assign gnt  = gnt_q;
    assign ack  = gnt_q & req;
    assign q    = q_q;
    assign busy = (state_q == GRANT);

endmodule
